// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = $clog2(MD_WIDTH);

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        SIGN = 2'b10
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_dp.sv
// Radix-2 iterative datapath: shift-add multiply or restoring divide on a
// 2*WIDTH accumulator ({remainder, quotient} for divide, {high, low} product for multiply).
module muldiv_dp
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic               r_div;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_next;

    // One iteration: the divide trial subtraction uses WIDTH+1 bits so the
    // bit shifted out of the partial remainder is not lost.
    always_comb begin
        w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
        if (r_div) begin
            if (w_diff[WIDTH] == 1'b0) begin
                w_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_next = {r_acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            w_next = {w_sum, r_acc[WIDTH-1:1]};
        end
    end

    // Accumulator and operand register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
        end else if (i_load) begin
            r_acc <= {{WIDTH{1'b0}}, i_a};
            r_b   <= i_b;
            r_div <= i_div;
        end else if (i_step) begin
            r_acc <= w_next;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the multi-cycle mult/div unit: FSM, HI/LO
// registers, sign correction, hazard stall request and HI/LO read mux.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic [1:0]       OpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             MfE,
    input  logic             MtE,
    input  logic             HiSelE,
    output logic             StallMD,
    output logic [WIDTH-1:0] HiLoE,
    output logic             Busy,
    output logic             DivZero
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam int              W2    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    muldiv_state_t      r_state;
    muldiv_op_t         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz_pend;
    logic               r_busy;
    logic               r_divzero;

    logic               w_accept;
    logic               w_signed;
    logic               w_is_div;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [W2-1:0]      w_acc;
    logic [W2-1:0]      w_prod_fix;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    assign w_accept = StartE & ~r_busy;
    assign w_signed = ~OpE[0];
    assign w_is_div = OpE[1];

    // Signed ops run on magnitudes; the sign is reapplied in SIGN.
    always_comb begin
        if (w_signed && SrcAE[WIDTH-1]) begin
            w_a = ~SrcAE + WIDTH'(1);
        end else begin
            w_a = SrcAE;
        end
        if (w_signed && SrcBE[WIDTH-1]) begin
            w_b = ~SrcBE + WIDTH'(1);
        end else begin
            w_b = SrcBE;
        end
    end

    muldiv_dp #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_accept),
        .i_step (r_state == RUN),
        .i_div  (w_is_div),
        .i_a    (w_a),
        .i_b    (w_b),
        .o_acc  (w_acc)
    );

    // Sign correction; a zero divisor forces an all-ones quotient.
    always_comb begin
        w_prod_fix = r_neg_q ? (~w_acc + W2'(1)) : w_acc;
        w_r_fix    = r_neg_r ? (~w_acc[W2-1:WIDTH] + WIDTH'(1)) : w_acc[W2-1:WIDTH];
        if (r_dz_pend) begin
            w_q_fix = '1;
        end else if (r_neg_q) begin
            w_q_fix = ~w_acc[WIDTH-1:0] + WIDTH'(1);
        end else begin
            w_q_fix = w_acc[WIDTH-1:0];
        end
    end

    // Control FSM, iteration counter, HI/LO and the DivZero pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_op      <= MULT;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz_pend <= 1'b0;
            r_busy    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_divzero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (StartE) begin
                        r_state   <= RUN;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_op      <= muldiv_op_t'(OpE);
                        r_neg_q   <= w_signed & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
                        r_neg_r   <= w_signed & w_is_div & SrcAE[WIDTH-1];
                        r_dz_pend <= w_is_div & (SrcBE == '0);
                    end else if (MtE) begin
                        if (HiSelE) begin
                            r_hi <= SrcAE;
                        end else begin
                            r_lo <= SrcAE;
                        end
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        r_state <= SIGN;
                    end
                end
                SIGN: begin
                    if (r_op == DIV || r_op == DIVU) begin
                        r_hi <= w_r_fix;
                        r_lo <= w_q_fix;
                    end else begin
                        r_hi <= w_prod_fix[W2-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_divzero <= r_dz_pend;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign StallMD = r_busy & (StartE | MfE | MtE);
    assign HiLoE   = HiSelE ? r_hi : r_lo;
    assign Busy    = r_busy;
    assign DivZero = r_divzero;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, randomized ops
// against an arithmetic reference model, and stall/reset corner sequences.
module tb_muldiv_ctrl;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          StartE;
    logic [1:0]    OpE;
    logic [W-1:0]  SrcAE;
    logic [W-1:0]  SrcBE;
    logic          MfE;
    logic          MtE;
    logic          HiSelE;
    logic          StallMD;
    logic [W-1:0]  HiLoE;
    logic          Busy;
    logic          DivZero;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    vec_t vecs [10];

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .StartE  (StartE),
        .OpE     (OpE),
        .SrcAE   (SrcAE),
        .SrcBE   (SrcBE),
        .MfE     (MfE),
        .MtE     (MtE),
        .HiSelE  (HiSelE),
        .StallMD (StallMD),
        .HiLoE   (HiLoE),
        .Busy    (Busy),
        .DivZero (DivZero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, truncating signed division.
    function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        longint sa, sb, q, rm;
        logic [2*W-1:0] r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        r  = '0;
        case (op)
            2'd0: r = 64'(sa * sb);
            2'd1: r = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input logic exp_dz);
        int busy_bad;
        int dz_bad;
        busy_bad = 0;
        dz_bad   = 0;
        OpE = op; SrcAE = a; SrcBE = b; StartE = 1'b1;
        tick();
        StartE = 1'b0; OpE = 2'($urandom); SrcAE = $urandom; SrcBE = $urandom;
        for (int c = 1; c <= 33; c++) begin
            if (Busy !== 1'b1)    busy_bad++;
            if (DivZero !== 1'b0) dz_bad++;
            tick();
        end
        check({tag, " busy_window"}, 32'(busy_bad), 32'd0);
        check({tag, " dz_early"}, 32'(dz_bad), 32'd0);
        check({tag, " busy_done"}, 32'(Busy), 32'd0);
        check({tag, " divzero"}, 32'(DivZero), 32'(exp_dz));
        MfE = 1'b1; HiSelE = 1'b1;
        #1;
        check({tag, " hi"}, HiLoE, exp_hi);
        check({tag, " stall_idle"}, 32'(StallMD), 32'd0);
        HiSelE = 1'b0;
        #1;
        check({tag, " lo"}, HiLoE, exp_lo);
        MfE = 1'b0;
        tick();
        check({tag, " dz_pulse_end"}, 32'(DivZero), 32'd0);
    endtask

    initial begin
        logic [2*W-1:0] exp;
        logic [1:0]     rop;
        logic [W-1:0]   ra, rb;
        int             stall_bad;

        vecs[0] = '{2'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{2'd2, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[6] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[7] = '{2'd3, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
        vecs[8] = '{2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[9] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};

        reset = 1'b1; StartE = 1'b0; OpE = 2'd0; SrcAE = '0; SrcBE = '0;
        MfE = 1'b0; MtE = 1'b0; HiSelE = 1'b0;
        tick(); tick();
        check("rst busy", 32'(Busy), 32'd0);
        check("rst divzero", 32'(DivZero), 32'd0);
        check("rst stall", 32'(StallMD), 32'd0);
        check("rst lo", HiLoE, 32'd0);
        HiSelE = 1'b1;
        #1;
        check("rst hi", HiLoE, 32'd0);
        HiSelE = 1'b0;
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dz);
        end

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            exp = model(rop, ra, rb);
            run_op($sformatf("rnd%0d op%0d %h/%h", i, rop, ra, rb), rop, ra, rb,
                   exp[2*W-1:W], exp[W-1:0], (rop[1] && rb == 32'd0));
        end

        // Stalled mfhi plus a stalled second start accepted back-to-back.
        stall_bad = 0;
        OpE = 2'd0; SrcAE = 32'd7; SrcBE = 32'hFFFF_FFFD; StartE = 1'b1;
        tick();
        StartE = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            if (c == 3) begin
                StartE = 1'b1; OpE = 2'd3; SrcAE = 32'd100; SrcBE = 32'd7;
            end
            if (c == 5) begin
                MfE = 1'b1; HiSelE = 1'b1;
            end
            #1;
            if (StallMD !== (c >= 3)) stall_bad++;
            if (Busy !== 1'b1)        stall_bad++;
            tick();
        end
        check("seq stall_window", 32'(stall_bad), 32'd0);
        #1;
        check("seq stall_drop", 32'(StallMD), 32'd0);
        check("seq busy_drop", 32'(Busy), 32'd0);
        check("seq mfhi_new", HiLoE, 32'hFFFF_FFFF);
        tick();
        StartE = 1'b0; MfE = 1'b0;
        check("seq b2b_accept", 32'(Busy), 32'd1);
        for (int c = 0; c < 33; c++) tick();
        check("seq b2b_done", 32'(Busy), 32'd0);
        HiSelE = 1'b0;
        #1;
        check("seq b2b_lo", HiLoE, 32'd14);
        HiSelE = 1'b1;
        #1;
        check("seq b2b_hi", HiLoE, 32'd2);
        tick();

        // Reset mid-operation, then mtlo/mflo without stalling.
        OpE = 2'd0; SrcAE = 32'd5; SrcBE = 32'd9; StartE = 1'b1;
        tick();
        StartE = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid busy", 32'(Busy), 32'd0);
        check("rstmid divzero", 32'(DivZero), 32'd0);
        HiSelE = 1'b1;
        #1;
        check("rstmid hi", HiLoE, 32'd0);
        HiSelE = 1'b0;
        #1;
        check("rstmid lo", HiLoE, 32'd0);
        MtE = 1'b1; SrcAE = 32'h0000_1234;
        #1;
        check("mtlo stall", 32'(StallMD), 32'd0);
        tick();
        MtE = 1'b0; MfE = 1'b1; HiSelE = 1'b0;
        #1;
        check("mflo value", HiLoE, 32'h0000_1234);
        check("mflo stall", 32'(StallMD), 32'd0);
        HiSelE = 1'b1;
        #1;
        check("mthi untouched", HiLoE, 32'd0);
        MfE = 1'b0;
        for (int c = 0; c < 30; c++) tick();
        check("rstmid stays idle", 32'(Busy), 32'd0);
        HiSelE = 1'b0;
        #1;
        check("rstmid lo kept", HiLoE, 32'h0000_1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
